// File: rtl/cr_iu_rbus_retire_pkg.sv
// Shared types for the IU retire bus: source encoding, field widths and the
// layout of the one-entry retire stage.
package cr_iu_rbus_retire_pkg;

  localparam int unsigned EXPT_VEC_W = 5;
  localparam int unsigned GPR_IDX_W  = 5;
  localparam int unsigned GPR_DATA_W = 32;

  typedef enum logic [1:0] {
    SRC_SPECIAL = 2'd0,
    SRC_LSU     = 2'd1,
    SRC_ALU     = 2'd2,
    SRC_NONE    = 2'd3
  } rbus_src_e;

  typedef struct packed {
    logic                  vld;
    logic                  expt_vld;
    logic [EXPT_VEC_W-1:0] expt_vec;
    logic                  flush;
    logic                  wen;
    logic [GPR_IDX_W-1:0]  dst;
    logic [GPR_DATA_W-1:0] data;
  } rbus_stage_t;

endpackage

// File: rtl/cr_iu_rbus_retire_st_cnt.sv
// Outstanding-store tracker for the retire bus.
// Ports:
//   clk_i, rst_n_i   clock and asynchronous active-low reset
//   inc_i            a store retired (issued to the bus)
//   dec_i            one store response returned
//   clr_store_i      a special flush is retiring; clear the sticky store flag
//   st_full_o        counter saturated
//   st_uncmplt_o     registered (count != 0)
//   store_o          sticky "store retired since last fence.i flush"
module cr_iu_rbus_st_cnt #(
  parameter int unsigned ST_CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_store_i,
  output logic st_full_o,
  output logic st_uncmplt_o,
  output logic store_o
);

  localparam logic [ST_CNT_W-1:0] CNT_MAX = '1;

  logic [ST_CNT_W-1:0] cnt_q, cnt_d;
  logic                uncmplt_q;
  logic                store_q, store_d;

  // Increment at max and decrement at zero are dropped; inc+dec cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ST_CNT_W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ST_CNT_W'(1);
    end
  end

  // Set has priority over clear.
  always_comb begin
    store_d = store_q;
    if (inc_i) begin
      store_d = 1'b1;
    end else if (clr_store_i) begin
      store_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      uncmplt_q <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      uncmplt_q <= (cnt_d != '0);
      store_q   <= store_d;
    end
  end

  assign st_full_o    = (cnt_q == CNT_MAX);
  assign st_uncmplt_o = uncmplt_q;
  assign store_o      = store_q;

endmodule

// File: rtl/cr_iu_rbus_retire.sv
// Retire-bus collector: fixed-priority (special > LSU > ALU) capture of
// single-cycle retire requests into a registered retire stage, which drives
// retire/exception/flush/GPR-writeback outputs, plus outstanding-store status.
// Ports:
//   cpuclk, cpurst_b            clock, asynchronous active-low reset
//   special_rbus_*              special unit retire request, flush, exception
//   lsu_rbus_*                  LSU retire request, writeback, store marker
//   alu_rbus_*                  ALU retire request and writeback
//   biu_st_cmplt                one store response returned
//   rbus_retire_*, rbus_gpr_*   retire stage outputs (one cycle after request)
//   wb_special_store            store retired since last fence.i flush
//   wb_special_st_uncmplt       stores outstanding
//   rbus_st_full                outstanding-store counter saturated
module cr_iu_rbus_retire
  import cr_iu_rbus_retire_pkg::*;
#(
  parameter int unsigned ST_CNT_W = 2
) (
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
  input  logic                  special_rbus_req,
  input  logic                  special_rbus_flush,
  input  logic                  special_rbus_expt_vld,
  input  logic [EXPT_VEC_W-1:0] special_rbus_expt_vec,
  input  logic                  lsu_rbus_req,
  input  logic                  lsu_rbus_wb_vld,
  input  logic [GPR_IDX_W-1:0]  lsu_rbus_wb_dst,
  input  logic [GPR_DATA_W-1:0] lsu_rbus_wb_data,
  input  logic                  lsu_rbus_store,
  input  logic                  alu_rbus_req,
  input  logic [GPR_IDX_W-1:0]  alu_rbus_wb_dst,
  input  logic [GPR_DATA_W-1:0] alu_rbus_wb_data,
  input  logic                  biu_st_cmplt,
  output logic                  rbus_retire_vld,
  output logic                  rbus_retire_expt_vld,
  output logic [EXPT_VEC_W-1:0] rbus_retire_expt_vec,
  output logic                  rbus_retire_flush,
  output logic                  rbus_gpr_wen,
  output logic [GPR_IDX_W-1:0]  rbus_gpr_dst,
  output logic [GPR_DATA_W-1:0] rbus_gpr_data,
  output logic                  wb_special_store,
  output logic                  wb_special_st_uncmplt,
  output logic                  rbus_st_full
);

  rbus_src_e   src;
  rbus_stage_t stage_q, stage_d;
  logic        flush_now;
  logic        store_acc;

  assign flush_now = stage_q.flush | stage_q.expt_vld;

  always_comb begin
    src = SRC_NONE;
    if (special_rbus_req) begin
      src = SRC_SPECIAL;
    end else if (lsu_rbus_req) begin
      src = SRC_LSU;
    end else if (alu_rbus_req) begin
      src = SRC_ALU;
    end
  end

  // An idle or killed cycle loads an all-zero stage so every output drops.
  always_comb begin
    stage_d = '0;
    if (!flush_now) begin
      case (src)
        SRC_SPECIAL: begin
          stage_d.vld      = 1'b1;
          stage_d.expt_vld = special_rbus_expt_vld;
          stage_d.expt_vec = special_rbus_expt_vec;
          stage_d.flush    = special_rbus_flush;
        end
        SRC_LSU: begin
          stage_d.vld  = 1'b1;
          stage_d.wen  = lsu_rbus_wb_vld;
          stage_d.dst  = lsu_rbus_wb_dst;
          stage_d.data = lsu_rbus_wb_data;
        end
        SRC_ALU: begin
          stage_d.vld  = 1'b1;
          stage_d.wen  = 1'b1;
          stage_d.dst  = alu_rbus_wb_dst;
          stage_d.data = alu_rbus_wb_data;
        end
        default: stage_d = '0;
      endcase
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign rbus_retire_vld      = stage_q.vld;
  assign rbus_retire_expt_vld = stage_q.expt_vld;
  assign rbus_retire_expt_vec = stage_q.expt_vec;
  assign rbus_retire_flush    = flush_now;
  assign rbus_gpr_wen         = stage_q.wen & ~stage_q.expt_vld & (stage_q.dst != '0);
  assign rbus_gpr_dst         = stage_q.dst;
  assign rbus_gpr_data        = stage_q.data;

  assign store_acc = (src == SRC_LSU) & lsu_rbus_store & ~flush_now;

  cr_iu_rbus_st_cnt #(
    .ST_CNT_W (ST_CNT_W)
  ) u_st_cnt (
    .clk_i        (cpuclk),
    .rst_n_i      (cpurst_b),
    .inc_i        (store_acc),
    .dec_i        (biu_st_cmplt),
    .clr_store_i  (stage_q.flush),
    .st_full_o    (rbus_st_full),
    .st_uncmplt_o (wb_special_st_uncmplt),
    .store_o      (wb_special_store)
  );

endmodule

// File: tb/tb_cr_iu_rbus_retire.sv
module tb_cr_iu_rbus_retire;

  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic        cpuclk;
  logic        cpurst_b;
  logic        special_rbus_req, special_rbus_flush, special_rbus_expt_vld;
  logic [4:0]  special_rbus_expt_vec;
  logic        lsu_rbus_req, lsu_rbus_wb_vld, lsu_rbus_store;
  logic [4:0]  lsu_rbus_wb_dst;
  logic [31:0] lsu_rbus_wb_data;
  logic        alu_rbus_req;
  logic [4:0]  alu_rbus_wb_dst;
  logic [31:0] alu_rbus_wb_data;
  logic        biu_st_cmplt;
  logic        rbus_retire_vld, rbus_retire_expt_vld, rbus_retire_flush, rbus_gpr_wen;
  logic [4:0]  rbus_retire_expt_vec, rbus_gpr_dst;
  logic [31:0] rbus_gpr_data;
  logic        wb_special_store, wb_special_st_uncmplt, rbus_st_full;

  cr_iu_rbus_retire #(.ST_CNT_W(CW)) dut (
    .cpuclk                (cpuclk),
    .cpurst_b              (cpurst_b),
    .special_rbus_req      (special_rbus_req),
    .special_rbus_flush    (special_rbus_flush),
    .special_rbus_expt_vld (special_rbus_expt_vld),
    .special_rbus_expt_vec (special_rbus_expt_vec),
    .lsu_rbus_req          (lsu_rbus_req),
    .lsu_rbus_wb_vld       (lsu_rbus_wb_vld),
    .lsu_rbus_wb_dst       (lsu_rbus_wb_dst),
    .lsu_rbus_wb_data      (lsu_rbus_wb_data),
    .lsu_rbus_store        (lsu_rbus_store),
    .alu_rbus_req          (alu_rbus_req),
    .alu_rbus_wb_dst       (alu_rbus_wb_dst),
    .alu_rbus_wb_data      (alu_rbus_wb_data),
    .biu_st_cmplt          (biu_st_cmplt),
    .rbus_retire_vld       (rbus_retire_vld),
    .rbus_retire_expt_vld  (rbus_retire_expt_vld),
    .rbus_retire_expt_vec  (rbus_retire_expt_vec),
    .rbus_retire_flush     (rbus_retire_flush),
    .rbus_gpr_wen          (rbus_gpr_wen),
    .rbus_gpr_dst          (rbus_gpr_dst),
    .rbus_gpr_data         (rbus_gpr_data),
    .wb_special_store      (wb_special_store),
    .wb_special_st_uncmplt (wb_special_st_uncmplt),
    .rbus_st_full          (rbus_st_full)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  // Reference model: what the instruction retiring this cycle presents,
  // and the store bookkeeping as plain integers.
  bit          m_vld, m_expt, m_sflush, m_wen, m_store, m_unc;
  logic [4:0]  m_vec, m_dst;
  logic [31:0] m_data;
  int          m_cnt;
  bit          n_vld, n_expt, n_sflush, n_wen, n_store, n_unc;
  logic [4:0]  n_vec, n_dst;
  logic [31:0] n_data;
  int          n_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_killed();
    return m_sflush || m_expt;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_expt = 0; m_sflush = 0; m_wen = 0; m_store = 0; m_unc = 0;
    m_vec = '0; m_dst = '0; m_data = '0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("retire_vld", 32'(rbus_retire_vld),      32'(m_vld));
    chk("expt_vld",   32'(rbus_retire_expt_vld), 32'(m_expt));
    chk("expt_vec",   32'(rbus_retire_expt_vec), 32'(m_vec));
    chk("flush",      32'(rbus_retire_flush),    32'(m_killed()));
    chk("gpr_wen",    32'(rbus_gpr_wen),         32'(m_wen));
    chk("gpr_dst",    32'(rbus_gpr_dst),         32'(m_dst));
    chk("gpr_data",   rbus_gpr_data,             m_data);
    chk("wb_store",   32'(wb_special_store),     32'(m_store));
    chk("st_uncmplt", 32'(wb_special_st_uncmplt), 32'(m_unc));
    chk("st_full",    32'(rbus_st_full),         32'(m_cnt == CMAX));
  endtask

  task automatic model_next();
    bit inc, dec;
    n_vld = 0; n_expt = 0; n_sflush = 0; n_wen = 0; n_vec = '0; n_dst = '0; n_data = '0;
    inc = 0;
    if (!m_killed()) begin
      if (special_rbus_req) begin
        n_vld = 1; n_expt = special_rbus_expt_vld; n_vec = special_rbus_expt_vec;
        n_sflush = special_rbus_flush;
      end else if (lsu_rbus_req) begin
        n_vld = 1; n_dst = lsu_rbus_wb_dst; n_data = lsu_rbus_wb_data;
        n_wen = lsu_rbus_wb_vld && (lsu_rbus_wb_dst != 0);
        inc = lsu_rbus_store;
      end else if (alu_rbus_req) begin
        n_vld = 1; n_dst = alu_rbus_wb_dst; n_data = alu_rbus_wb_data;
        n_wen = (alu_rbus_wb_dst != 0);
      end
    end
    dec = biu_st_cmplt;
    assert (!(inc && !dec && m_cnt == CMAX)) else $error("store issued at saturation");
    assert (!(dec && !inc && m_cnt == 0)) else $error("store response with none outstanding");
    n_cnt = m_cnt;
    if (inc && !dec && m_cnt < CMAX) n_cnt = m_cnt + 1;
    if (dec && !inc && m_cnt > 0)    n_cnt = m_cnt - 1;
    n_unc = (n_cnt != 0);
    if (inc)           n_store = 1;
    else if (m_sflush) n_store = 0;
    else               n_store = m_store;
  endtask

  task automatic commit();
    m_vld = n_vld; m_expt = n_expt; m_sflush = n_sflush; m_wen = n_wen;
    m_vec = n_vec; m_dst = n_dst; m_data = n_data;
    m_cnt = n_cnt; m_unc = n_unc; m_store = n_store;
  endtask

  // Inputs are set at posedge+1; outputs are checked at negedge.
  task automatic tick();
    @(negedge cpuclk);
    check_outputs();
    model_next();
    @(posedge cpuclk);
    commit();
    #1;
  endtask

  task automatic idle();
    special_rbus_req = 0; special_rbus_flush = 0; special_rbus_expt_vld = 0;
    special_rbus_expt_vec = '0;
    lsu_rbus_req = 0; lsu_rbus_wb_vld = 0; lsu_rbus_wb_dst = '0; lsu_rbus_wb_data = '0;
    lsu_rbus_store = 0;
    alu_rbus_req = 0; alu_rbus_wb_dst = '0; alu_rbus_wb_data = '0;
    biu_st_cmplt = 0;
  endtask

  task automatic alu(input logic [4:0] d, input logic [31:0] v);
    idle(); alu_rbus_req = 1; alu_rbus_wb_dst = d; alu_rbus_wb_data = v;
  endtask

  task automatic lsu(input bit wb, input logic [4:0] d, input logic [31:0] v, input bit st);
    idle(); lsu_rbus_req = 1; lsu_rbus_wb_vld = wb; lsu_rbus_wb_dst = d;
    lsu_rbus_wb_data = v; lsu_rbus_store = st;
  endtask

  task automatic spc(input bit f, input bit e, input logic [4:0] vec);
    idle(); special_rbus_req = 1; special_rbus_flush = f;
    special_rbus_expt_vld = e; special_rbus_expt_vec = vec;
  endtask

  always @(posedge cpuclk) begin
    if (cpurst_b) begin
      assert ((int'(special_rbus_req) + int'(lsu_rbus_req) + int'(alu_rbus_req)) <= 1)
        else $error("simultaneous retire requests");
    end
  end

  initial begin
    idle();
    cpurst_b = 0;
    model_reset();
    #3 check_outputs();
    @(posedge cpuclk); #1 cpurst_b = 1;

    // ALU writeback, then idle
    alu(5'd5, 32'h1234); tick();
    idle(); tick(); tick();
    // LSU load to x0: retires without writing
    lsu(1, 5'd0, 32'hdead_beef, 0); tick();
    idle(); tick();
    // exception from special, ALU request in the flush cycle is dropped
    spc(0, 1, 5'h0B); tick();
    alu(5'd7, 32'h55); tick();
    idle(); tick(); tick();
    // two stores then fence.i with two outstanding
    lsu(0, 5'd0, 32'h0, 1); tick();
    lsu(0, 5'd0, 32'h0, 1); tick();
    spc(1, 0, 5'h0); tick();
    idle(); tick(); tick();
    biu_st_cmplt = 1; tick();
    idle(); tick();
    biu_st_cmplt = 1; tick();
    idle(); tick(); tick();
    // saturate, then store retire coinciding with a response
    repeat (3) begin lsu(1, 5'd3, 32'h77, 1); tick(); end
    idle(); tick();
    lsu(0, 5'd0, 32'h0, 1); biu_st_cmplt = 1; tick();
    idle(); tick();
    idle(); biu_st_cmplt = 1; tick();
    alu(5'd9, 32'hcafe); tick();
    // asynchronous reset with count=2 and a valid stage
    idle();
    cpurst_b = 0;
    #1 model_reset();
    check_outputs();
    @(posedge cpuclk); #1 cpurst_b = 1;
    tick(); tick();

    // randomized single-source traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit b;
      idle();
      r = int'($urandom_range(0, 9));
      b = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      case (r)
        0: spc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 5'($urandom));
        1, 2, 3: lsu($urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                     !m_killed() && (m_cnt < CMAX || b) && $urandom_range(0, 1) == 1);
        4, 5, 6: alu(5'($urandom), $urandom);
        default: ;
      endcase
      biu_st_cmplt = b;
      tick();
    end
    idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_iu_rbus_retire.md
Name: cr_iu_rbus_retire

Overview:
Retire-bus collector and writeback-store tracker in the E902 IU. Arbitrates single-cycle retire requests from the special, LSU and ALU units into a one-entry registered retire stage. From that stage it drives the retire, exception, flush and GPR-writeback outputs. It also tracks outstanding stores and produces the wb_special_store and wb_special_st_uncmplt status consumed by the special unit for fence.i sequencing.

Parameters:
ST_CNT_W, 2, width of outstanding-store counter; maximum outstanding = 2^ST_CNT_W-1

Ports:
cpuclk  in  1  core clock
cpurst_b  in  1  asynchronous active-low reset
special_rbus_req  in  1  special unit retire request
special_rbus_flush  in  1  special retire requires pipeline flush (fence.i)
special_rbus_expt_vld  in  1  special retire carries exception
special_rbus_expt_vec  in  5  exception vector
lsu_rbus_req  in  1  LSU retire request
lsu_rbus_wb_vld  in  1  LSU retire writes GPR
lsu_rbus_wb_dst  in  5  LSU destination GPR
lsu_rbus_wb_data  in  32  LSU writeback data
lsu_rbus_store  in  1  LSU retiring instruction is a store (issued to bus)
alu_rbus_req  in  1  ALU retire request
alu_rbus_wb_dst  in  5  ALU destination GPR (always writes)
alu_rbus_wb_data  in  32  ALU writeback data
biu_st_cmplt  in  1  one store response returned from bus
rbus_retire_vld  out  1  instruction retired this cycle
rbus_retire_expt_vld  out  1  retiring instruction raised exception
rbus_retire_expt_vec  out  5  exception vector
rbus_retire_flush  out  1  flush front end this cycle
rbus_gpr_wen  out  1  GPR write enable
rbus_gpr_dst  out  5  GPR index
rbus_gpr_data  out  32  GPR write data
wb_special_store  out  1  a store retired since last fence.i flush
wb_special_st_uncmplt  out  1  outstanding store count nonzero
rbus_st_full  out  1  outstanding counter saturated; LSU must hold stores

Behaviour:
- Reset: all outputs 0; retire stage invalid; store counter 0; store flag 0.
- Arbitration, fixed priority special > LSU > ALU. Acceptance is unconditional (no grant); losers in the same cycle are dropped, and rbus_retire_expt_vld is NOT set for them. Simultaneous requests are a source-side protocol error; the bench flags them via assertion.
- Latency: request in cycle N -> outputs valid in cycle N+1 for exactly one cycle. Back-to-back requests retire every cycle.
- Retire stage captures vld, expt_vld, expt_vec, flush, wen, dst, data from the winner. Special: wen=0. LSU: wen=lsu_rbus_wb_vld. ALU: wen=1.
- rbus_gpr_wen is forced 0 when expt_vld=1 or dst==0.
- rbus_retire_flush = stage.flush | stage.expt_vld.
- Flush kill: in the cycle rbus_retire_flush=1, incoming requests are discarded and the stage goes invalid next cycle. One bubble follows every flush.
- Store counter:
  - +1 when LSU wins with lsu_rbus_store=1; -1 on biu_st_cmplt.
  - Simultaneous increment and decrement: count unchanged.
  - Decrement at 0 is ignored (assertion).
  - rbus_st_full = (count == max). An increment at max is ignored (assertion).
- wb_special_st_uncmplt = (count != 0), registered, so it is valid the cycle after the counter update.
- wb_special_store: sticky flag.
  - Set when a store retires (LSU wins with lsu_rbus_store=1).
  - Cleared in the cycle after rbus_retire_flush from a special flush.
  - Set wins over clear when both occur in the same cycle.
- Reset mid-operation: asynchronous clear of stage, counter and flag; in-flight bus responses after reset are the BIU's concern.

Decomposition:
- Shared package/defines: source encoding (SRC_SPECIAL=0, SRC_LSU=1, SRC_ALU=2), 5-bit exception vector width, GPR index width.
- One sub-module: cr_iu_rbus_st_cnt, holding the store counter, full/uncmplt status and the sticky store flag.

Test Plan:
- ALU req dst=5, data=0x1234 in cycle N -> cycle N+1: retire_vld=1, gpr_wen=1, dst=5, data=0x1234; cycle N+2 all 0.
- LSU load to dst=0 -> retire_vld=1, gpr_wen=0.
- Special req with expt_vld=1, vec=0x0B -> retire_expt_vld=1, vec=0x0B, flush=1, gpr_wen=0.
- Same-cycle ALU req in the flush cycle -> dropped.
- Two LSU stores retired, then special fence.i flush while count=2:
  - wb_special_st_uncmplt stays 1 until the second biu_st_cmplt, then 0 next cycle.
  - wb_special_store clears after the flush retires.
- Three stores with ST_CNT_W=2 -> rbus_st_full=1. Simultaneous store retire and biu_st_cmplt -> count stays 3.
- Assert cpurst_b low with count=2 and stage valid -> all outputs 0 immediately; counter 0 after release.
